// File: rtl/swap_mem_sequencer.sv
// Locked read-then-write sequencer for ARM SWP/SWPB: reads the old memory value,
// writes the register value under a continuous bus lock, and returns the old value.
module swap_mem_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_lock,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  byte_q, byte_d;
   logic [1:0]            lane;
   logic [7:0]            rd_byte;
   logic                  in_access;

   assign lane      = addr_q[1:0];
   assign in_access = (state_q == READ) || (state_q == WRITE);

   // Little-endian lane select: lane 0 is bits 7:0
   always_comb begin
      rd_byte = mem_rdata[7:0];
      case (lane)
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         2'd3:    rd_byte = mem_rdata[31:24];
         default: rd_byte = mem_rdata[7:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      byte_d  = byte_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = addr;
               wdata_d = wdata;
               byte_d  = byte_en;
               state_d = READ;
            end
         end
         READ: begin
            if (mem_ready) begin
               rdata_d = byte_q ? {{(DATA_WIDTH-8){1'b0}}, rd_byte} : mem_rdata;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (mem_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         byte_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         byte_q  <= byte_d;
      end
   end

   // Outputs decode straight from the state flop so reset clears them without a clock
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      rdata_out = rdata_q;
      mem_re    = (state_q == READ);
      mem_we    = (state_q == WRITE);
      mem_lock  = in_access;
      mem_addr  = in_access ? addr_q : '0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      if (state_q == WRITE) begin
         if (byte_q) begin
            mem_be    = 4'b0001 << lane;
            mem_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
         end else begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_swap_mem_sequencer.sv
// Scoreboard bench for swap_mem_sequencer: a word-array memory model answers the
// memory port, and expected swap results are queued when each swap is launched.
module tb_swap_mem_sequencer;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rd;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] newword;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata_out;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_lock;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic [31:0] mem [0:255];
   exp_t        sb_q[$];
   logic [31:0] last_rdata;
   int          vectors;
   int          miscompares;

   always #5 clk = ~clk;

   swap_mem_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .byte_en   (byte_en),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata_out (rdata_out),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_lock  (mem_lock),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_rdata"}, rdata_out, 32'd0);
      checkOutput({tag, "_re"}, 32'(mem_re), 32'd0);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
      checkOutput({tag, "_be"}, 32'(mem_be), 32'd0);
      checkOutput({tag, "_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_lock"}, 32'(mem_lock), 32'd0);
   endtask

   // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic be,
                                input int rd_waits, input int wr_waits, input logic hijack,
                                input logic chain, input logic [31:0] a2, input logic [31:0] wd2,
                                input logic be2);
      exp_t        e;
      logic [31:0] old_word;
      logic [7:0]  lb;
      int          sh;
      int          rd_cyc;
      int          wr_cyc;
      int          done_cnt;
      int          done_cyc;
      logic        finished;
      old_word = mem[a[9:2]];
      sh       = 8 * int'(a[1:0]);
      e.addr   = a;
      if (be) begin
         lb        = 8'(old_word >> sh);
         e.rd      = {24'h0, lb};
         e.be      = 4'(1 << a[1:0]);
         e.wd      = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         e.newword = old_word;
         e.newword[sh +: 8] = wd[7:0];
      end else begin
         e.rd      = old_word;
         e.be      = 4'hF;
         e.wd      = wd;
         e.newword = wd;
      end
      sb_q.push_back(e);
      start     = 1'b1;
      addr      = a;
      wdata     = wd;
      byte_en   = be;
      mem_ready = 1'b0;
      mem_rdata = 32'hA5A5_5A5A;
      rd_cyc    = 0;
      wr_cyc    = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      finished  = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start     = 1'b0;
         mem_ready = 1'b0;
         mem_rdata = 32'hA5A5_5A5A;
         checkOutput("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
         if (cyc == 1) checkOutput("read_first_cycle", 32'(mem_re), 32'd1);
         if (mem_re) begin
            rd_cyc++;
            checkOutput("read_lock", 32'(mem_lock), 32'd1);
            checkOutput("read_addr", mem_addr, a);
            checkOutput("rdata_held", rdata_out, last_rdata);
            mem_rdata = mem[mem_addr[9:2]];
            mem_ready = (rd_cyc > rd_waits);
            if (hijack) begin
               start = 1'b1;
               addr  = 32'h200;
            end
         end else if (mem_we) begin
            wr_cyc++;
            checkOutput("write_lock", 32'(mem_lock), 32'd1);
            checkOutput("write_addr", mem_addr, a);
            checkOutput("write_be", 32'(mem_be), 32'(e.be));
            checkOutput("write_data", mem_wdata, e.wd);
            mem_ready = (wr_cyc > wr_waits);
            if (mem_ready) begin
               for (int l = 0; l < 4; l++)
                  if (mem_be[l]) mem[mem_addr[9:2]][8*l +: 8] = mem_wdata[8*l +: 8];
            end
         end else if (done) begin
            done_cnt++;
            done_cyc = cyc;
            mem_ready = 1'b1;
            checkOutput("done_lock", 32'(mem_lock), 32'd0);
            checkOutput("done_busy", 32'(busy), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               checkOutput("swap_rdata", rdata_out, e.rd);
               checkOutput("swap_memword", mem[e.addr[9:2]], e.newword);
               last_rdata = e.rd;
            end
            if (chain) begin
               start   = 1'b1;
               addr    = a2;
               wdata   = wd2;
               byte_en = be2;
            end
         end else begin
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_lock", 32'(mem_lock), 32'd0);
            checkOutput("done_pulses", 32'(done_cnt), 32'd1);
            checkOutput("done_latency", 32'(done_cyc), 32'(3 + rd_waits + wr_waits));
            checkOutput("read_cycles", 32'(rd_cyc), 32'(rd_waits + 1));
            checkOutput("write_cycles", 32'(wr_cyc), 32'(wr_waits + 1));
            if (done_cnt == 0 && sb_q.size() > 0) void'(sb_q.pop_front());
            if (chain) start = 1'b1;
            finished = 1'b1;
            break;
         end
      end
      checkOutput("seq_finished", 32'(finished), 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_rdata  = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset     = 1'b1;
      start     = 1'b0;
      byte_en   = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      mem_rdata = 32'h0;
      mem_ready = 1'b0;
      #12;
      checkAllZero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      mem[8'h40] = 32'h1234_5678;
      applyStimulus(32'h100, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      mem[8'h40] = 32'h1122_3344;
      applyStimulus(32'h102, 32'h0000_00AB, 1'b1, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("byte_lane2_word", mem[8'h40], 32'h11AB_3344);

      mem[8'h42] = 32'hCAFE_0001;
      applyStimulus(32'h108, 32'h55AA_55AA, 1'b0, 3, 2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      mem[8'h40] = 32'h0F0F_0F0F;
      mem[8'h80] = 32'h7777_7777;
      applyStimulus(32'h100, 32'h1357_9BDF, 1'b0, 1, 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("ignored_start_mem200", mem[8'h80], 32'h7777_7777);

      for (int l = 0; l < 4; l++) begin
         mem[8'h44] = 32'hA1B2_C3D4;
         applyStimulus(32'h110 + 32'(l), $urandom, 1'b1, l % 2, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end

      mem[8'h40] = 32'h0102_0304;
      mem[8'h41] = 32'h0506_0708;
      applyStimulus(32'h100, 32'h1111_1111, 1'b0, 0, 0, 1'b0, 1'b1, 32'h104, 32'h2222_2222, 1'b0);
      applyStimulus(32'h104, 32'h2222_2222, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Abort a swap with reset while the write is stalled
      mem[8'h43] = 32'h0BAD_F00D;
      start     = 1'b1;
      addr      = 32'h10C;
      wdata     = 32'hCAFE_F00D;
      byte_en   = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("abort_read", 32'(mem_re), 32'd1);
      mem_rdata = mem[8'h43];
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("abort_write", 32'(mem_we), 32'd1);
      mem_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkAllZero("abort");
      @(negedge clk);
      reset      = 1'b0;
      mem_ready  = 1'b1;
      last_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("post_abort_we", 32'(mem_we), 32'd0);
         checkOutput("post_abort_busy", 32'(busy), 32'd0);
      end
      checkOutput("post_abort_mem", mem[8'h43], 32'h0BAD_F00D);

      applyStimulus(32'h10C, 32'h600D_CAFE, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
